// File: rtl/adc_fe_pkg.sv
// Shared constants for the ADC front end: register map, gain unity,
// saturation limits, STATUS layout, and the Q4.12 rescale/saturate helper.
package adc_fe_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hFE000140;

    localparam logic [31:0] REG_CONTROL = 32'h00;
    localparam logic [31:0] REG_OFFSET  = 32'h04;
    localparam logic [31:0] REG_GAIN    = 32'h08;
    localparam logic [31:0] REG_GAP     = 32'h0C;
    localparam logic [31:0] REG_STATUS  = 32'h10;
    localparam logic [31:0] REG_DROPCNT = 32'h14;
    localparam logic [31:0] REG_SATCNT  = 32'h18;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam int STATUS_OVF_BIT   = 16;
    localparam int STATUS_EMPTY_BIT = 17;
    localparam int STATUS_FULL_BIT  = 18;

    localparam logic [15:0] GAIN_ONE = 16'h1000;

    localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
    localparam logic signed [15:0] S16_MIN = 16'sh8000;

    // Drop the 12 fractional gain bits (floor) and clip to int16.
    // Returns {saturated, sample}.
    function automatic logic [16:0] sat_q12(input logic signed [33:0] p);
        logic signed [33:0] q;
        q = p >>> 12;
        if (q > 34'sd32767)       return {1'b1, S16_MAX};
        else if (q < -34'sd32768) return {1'b1, S16_MIN};
        return {1'b0, q[15:0]};
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO with registered read data. A push while full is
// only taken when a pop frees a slot in the same cycle. Flush empties the
// queue but leaves dout alone so the last popped sample stays visible.
module adc_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop) && !flush;

    // storage write
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // registered read port, holds between pops
    always_ff @(posedge clk) begin
        if (rst)         dout <= '0;
        else if (do_pop) dout <= mem[rd_ptr];
    end

endmodule

// File: rtl/adc_front_end.sv
// ADC conditioning front end: offset removal, Q4.12 gain with int16
// saturation, sample FIFO, and a rate-limited ADC/PushADC output stream.
// Configured through the shared 32-bit register bus.
module adc_front_end
    import adc_fe_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] Wdata,
    input  logic        write,
    input  logic        read,
    output logic [31:0] Rdata,
    input  logic [15:0] raw_sample,
    input  logic        raw_valid,
    output logic [15:0] ADC,
    output logic        PushADC,
    output logic        Overflow
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // register bus decode
    logic [31:0] reg_off;
    logic        wr_ctrl, wr_offset, wr_gain, wr_gap, wr_status;

    assign reg_off   = addr - BASE_ADDR;
    assign wr_ctrl   = write && (reg_off == REG_CONTROL);
    assign wr_offset = write && (reg_off == REG_OFFSET);
    assign wr_gain   = write && (reg_off == REG_GAIN);
    assign wr_gap    = write && (reg_off == REG_GAP);
    assign wr_status = write && (reg_off == REG_STATUS);

    logic        enable;
    logic [15:0] offset_r, gain_r, gap_r;
    logic        ovf;
    logic [31:0] drop_cnt, sat_cnt;
    logic        clr, dis;

    assign clr = wr_ctrl && Wdata[CTRL_CLR_BIT];
    // The edge that turns enable off also flushes; nothing may enter or
    // leave the FIFO on that edge.
    assign dis = enable && wr_ctrl && !Wdata[CTRL_EN_BIT];

    // datapath pipeline
    logic [2:1]         vld_pipe;
    logic signed [16:0] s1_d;
    logic signed [33:0] s2_p;
    logic [16:0]        s3_res;
    logic               s3_vld, s3_sat;
    logic [15:0]        s3_q;

    // valids: raw_valid ignored while disabled, cleared on disable
    always_ff @(posedge clk) begin
        if (rst || !enable || dis) vld_pipe <= '0;
        else                       vld_pipe <= {vld_pipe[1], raw_valid};
    end

    // S1 offset removal, S2 gain; each stage uses the register value current at entry
    always_ff @(posedge clk) begin
        s1_d <= {raw_sample[15], raw_sample} - {offset_r[15], offset_r};
        s2_p <= 34'(s1_d) * 34'($signed({1'b0, gain_r}));
    end

    assign s3_res = sat_q12(s2_p);
    assign s3_sat = s3_res[16];
    assign s3_q   = s3_res[15:0];
    assign s3_vld = vld_pipe[2] && enable && !dis;

    // FIFO and output scheduler
    logic [LVL_W-1:0] level;
    logic             full, empty, pop, drop;
    logic [15:0]      gap_cnt;

    assign pop  = enable && !dis && !empty && (gap_cnt == '0);
    assign drop = s3_vld && full && !pop;

    adc_sample_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(16)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(dis),
        .push (s3_vld),
        .pop  (pop),
        .din  (s3_q),
        .dout (ADC),
        .level(level),
        .full (full),
        .empty(empty)
    );

    // minimum spacing between pushes; reloaded on every pop
    always_ff @(posedge clk) begin
        if (rst)                  gap_cnt <= '0;
        else if (pop)             gap_cnt <= gap_r;
        else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 16'd1;
    end

    // one-cycle strobe alongside the freshly registered ADC value
    always_ff @(posedge clk) begin
        if (rst) PushADC <= 1'b0;
        else     PushADC <= pop;
    end

    // configuration registers and counters; clear beats any same-cycle event
    always_ff @(posedge clk) begin
        if (rst) begin
            enable   <= 1'b0;
            offset_r <= '0;
            gain_r   <= GAIN_ONE;
            gap_r    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            sat_cnt  <= '0;
        end else begin
            if (wr_ctrl)   enable   <= Wdata[CTRL_EN_BIT];
            if (wr_offset) offset_r <= Wdata[15:0];
            if (wr_gain)   gain_r   <= Wdata[15:0];
            if (wr_gap)    gap_r    <= Wdata[15:0];
            if (clr) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
                sat_cnt  <= '0;
            end else begin
                if (drop)                                ovf <= 1'b1;
                else if (wr_status && Wdata[STATUS_OVF_BIT]) ovf <= 1'b0;
                if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
                if (s3_vld && s3_sat)       sat_cnt  <= sat_cnt + 32'd1;
            end
        end
    end

    assign Overflow = ovf;

    // read mux, no side effects
    always_comb begin
        Rdata = '0;
        if (read && !rst) begin
            case (reg_off)
                REG_CONTROL: Rdata[CTRL_EN_BIT] = enable;
                REG_OFFSET:  Rdata[15:0] = offset_r;
                REG_GAIN:    Rdata[15:0] = gain_r;
                REG_GAP:     Rdata[15:0] = gap_r;
                REG_STATUS: begin
                    Rdata[7:0]              = 8'(level);
                    Rdata[STATUS_OVF_BIT]   = ovf;
                    Rdata[STATUS_EMPTY_BIT] = empty;
                    Rdata[STATUS_FULL_BIT]  = full;
                end
                REG_DROPCNT: Rdata = drop_cnt;
                REG_SATCNT:  Rdata = sat_cnt;
                default:     Rdata = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{Wdata[31:17]};

endmodule

// File: tb/tb_adc_front_end.sv
// Bench for adc_front_end: register/sample vector tables, hand sequences for
// gap spacing, overflow, clear, disable and mid-stream reset, then random
// traffic, all checked against a cycle-level queue model of the behaviour.
module tb_adc_front_end;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hFE000140;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, Wdata, Rdata;
    logic        write, read;
    logic [15:0] raw_sample, ADC;
    logic        raw_valid, PushADC, Overflow;

    always #5 clk = ~clk;

    adc_front_end #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
        .read(read), .Rdata(Rdata), .raw_sample(raw_sample),
        .raw_valid(raw_valid), .ADC(ADC), .PushADC(PushADC), .Overflow(Overflow)
    );

    int n_cmp = 0, n_bad = 0;

    function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic        m_en, m_v1, m_v2, m_push, m_ovf;
    logic [15:0] m_off, m_gain, m_gap_r, m_adc;
    int          m_gap;
    longint      m_d1, m_p2;
    logic [15:0] m_q[$];
    logic [31:0] m_drop, m_sat;

    always @(posedge clk) begin : model
        bit pop, dis, clr, wr, sat;
        longint q;
        if (rst) begin
            m_en = 0; m_off = 0; m_gain = 16'h1000; m_gap_r = 0; m_gap = 0;
            m_v1 = 0; m_v2 = 0; m_q.delete(); m_adc = 0; m_push = 0;
            m_ovf = 0; m_drop = 0; m_sat = 0;
        end else begin
            dis = m_en && write && addr == BASE && !Wdata[0];
            clr = write && addr == BASE && Wdata[1];
            pop = m_en && !dis && m_q.size() != 0 && m_gap == 0;
            wr  = m_v2 && m_en && !dis;
            m_push = pop;
            if (pop) m_adc = m_q.pop_front();
            if (write && addr == BASE + 32'h10 && Wdata[16]) m_ovf = 0;
            if (wr) begin
                q = m_p2 >>> 12;
                sat = 0;
                if (q > 32767) begin q = 32767; sat = 1; end
                else if (q < -32768) begin q = -32768; sat = 1; end
                if (sat) m_sat++;
                if (m_q.size() < DEPTH) m_q.push_back(16'(q));
                else begin
                    m_ovf = 1;
                    if (m_drop != 32'hFFFFFFFF) m_drop++;
                end
            end
            if (clr) begin m_drop = 0; m_sat = 0; m_ovf = 0; end
            if (dis) m_q.delete();
            if (pop) m_gap = int'(m_gap_r);
            else if (m_gap > 0) m_gap--;
            if (!m_en || dis) begin
                m_v1 = 0; m_v2 = 0;
            end else begin
                m_v2 = m_v1;
                m_p2 = m_d1 * longint'(m_gain);
                m_v1 = raw_valid;
                m_d1 = longint'($signed(raw_sample)) - longint'($signed(m_off));
            end
            if (write) begin
                if (addr == BASE)          m_en    = Wdata[0];
                if (addr == BASE + 32'h04) m_off   = Wdata[15:0];
                if (addr == BASE + 32'h08) m_gain  = Wdata[15:0];
                if (addr == BASE + 32'h0C) m_gap_r = Wdata[15:0];
            end
        end
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(m_q.size());
        s[16] = m_ovf;
        s[17] = (m_q.size() == 0);
        s[18] = (m_q.size() == DEPTH);
        return s;
    endfunction

    // ---------------- per-cycle monitor ----------------
    bit chk_en = 0, gap_chk = 0, have_prev = 0;
    int cyc = 0, prev_cyc = 0, n_push = 0;

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("push_strobe", 32'(PushADC), 32'(m_push));
            check("adc_value", 32'(ADC), 32'(m_adc));
            check("overflow_pin", 32'(Overflow), 32'(m_ovf));
        end
        if (!gap_chk) have_prev = 0;
        if (PushADC) begin
            n_push++;
            if (gap_chk) begin
                if (have_prev) check("push_interval", 32'(cyc - prev_cyc), 32'd10);
                prev_cyc = cyc;
                have_prev = 1;
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1; addr = a; Wdata = d;
        @(negedge clk);
        write = 0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        read = 1; addr = a;
        #1 d = Rdata;
        read = 0;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [15:0] raw, off, gain, exp;
        logic [31:0] sat_total;
    } smp_vec_t;

    rd_vec_t  rv[10];
    smp_vec_t sv[10];

    task automatic reset_table();
        logic [31:0] d;
        for (int i = 0; i < 10; i++) begin
            bus_rd(rv[i].a, d);
            check(rv[i].nm, d, rv[i].exp);
        end
        check("rst_adc", 32'(ADC), 32'h0);
        check("rst_push", 32'(PushADC), 32'h0);
        check("rst_overflow", 32'(Overflow), 32'h0);
    endtask

    task automatic send_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            raw_valid = 1; raw_sample = 16'($urandom_range(0, 16'h3FFF));
        end
        @(negedge clk);
        raw_valid = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : test
        logic [31:0] d;
        int lat, p0, pushed, r;

        rv[0] = '{"rd_control", BASE + 32'h00, 32'h0};
        rv[1] = '{"rd_offset",  BASE + 32'h04, 32'h0};
        rv[2] = '{"rd_gain",    BASE + 32'h08, 32'h1000};
        rv[3] = '{"rd_gap",     BASE + 32'h0C, 32'h0};
        rv[4] = '{"rd_status",  BASE + 32'h10, 32'h0002_0000};
        rv[5] = '{"rd_dropcnt", BASE + 32'h14, 32'h0};
        rv[6] = '{"rd_satcnt",  BASE + 32'h18, 32'h0};
        rv[7] = '{"rd_unmapped_hi", BASE + 32'h1C, 32'h0};
        rv[8] = '{"rd_below_base",  BASE - 32'h04, 32'h0};
        rv[9] = '{"rd_misaligned",  BASE + 32'h0A, 32'h0};

        //          raw       off       gain      expected  SATCNT after
        sv[0] = '{16'h0110, 16'h0010, 16'h1000, 16'h0100, 32'd0};
        sv[1] = '{16'h4000, 16'h0000, 16'h4000, 16'h7FFF, 32'd1};
        sv[2] = '{16'hC000, 16'h0000, 16'h4000, 16'h8000, 32'd2};
        sv[3] = '{16'h0100, 16'h0000, 16'h0800, 16'h0080, 32'd2};
        sv[4] = '{16'hFF00, 16'h0000, 16'h1800, 16'hFE80, 32'd2};
        sv[5] = '{16'h7FFF, 16'hFFFF, 16'h1000, 16'h7FFF, 32'd3};
        sv[6] = '{16'h8000, 16'h0001, 16'h1000, 16'h8000, 32'd4};
        sv[7] = '{16'hFFFF, 16'h0000, 16'h0800, 16'hFFFF, 32'd4};
        sv[8] = '{16'h1234, 16'h0234, 16'hFFFF, 16'h7FFF, 32'd5};
        sv[9] = '{16'h0003, 16'h0000, 16'h0001, 16'h0000, 32'd5};

        rst = 1; write = 0; read = 0; addr = 0; Wdata = 0;
        raw_valid = 0; raw_sample = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        rst = 0;

        // reset state, and Rdata stays 0 with read low
        reset_table();
        addr = BASE + 32'h08; read = 0;
        #1 check("rdata_idle", Rdata, 32'h0);

        // single-sample conversions, latency, saturation counting
        bus_wr(BASE + 32'h0C, 32'd0);
        bus_wr(BASE, 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus_wr(BASE + 32'h04, 32'(sv[i].off));
            bus_wr(BASE + 32'h08, 32'(sv[i].gain));
            @(negedge clk);
            raw_valid = 1; raw_sample = sv[i].raw;
            lat = 0;
            do begin
                @(negedge clk);
                raw_valid = 0;
                lat++;
            end while (!PushADC && lat < 12);
            check("sample_latency_4to5", 32'(lat >= 4 && lat <= 5), 32'd1);
            check("sample_adc", 32'(ADC), 32'(sv[i].exp));
            bus_rd(BASE + 32'h18, d);
            check("sample_satcnt", d, sv[i].sat_total);
        end

        // GAP=9 burst of 20: pushes 10 cycles apart, two drops
        bus_wr(BASE + 32'h04, 32'd0);
        bus_wr(BASE + 32'h08, 32'h1000);
        bus_wr(BASE + 32'h0C, 32'd9);
        p0 = n_push;
        gap_chk = 1;
        send_burst(20);
        repeat (200) @(negedge clk);
        gap_chk = 0;
        pushed = n_push - p0;
        check("burst_pushed", 32'(pushed), 32'd18);
        bus_rd(BASE + 32'h14, d);
        check("burst_dropcnt", d, 32'd2);
        check("burst_drop_plus_push", d + 32'(pushed), 32'd20);
        bus_rd(BASE + 32'h10, d);
        check("burst_status_ovf", 32'(d[16]), 32'd1);
        check("burst_overflow_pin", 32'(Overflow), 32'd1);

        // sticky overflow clear via STATUS, counter clear via CONTROL
        bus_wr(BASE + 32'h10, 32'h0001_0000);
        bus_rd(BASE + 32'h10, d);
        check("status_after_ovf_clr", d, 32'h0002_0000);
        bus_wr(BASE, 32'd3);
        bus_rd(BASE + 32'h14, d);
        check("dropcnt_cleared", d, 32'd0);
        bus_rd(BASE + 32'h18, d);
        check("satcnt_cleared", d, 32'd0);
        bus_rd(BASE, d);
        check("control_clear_selfclr", d, 32'd1);

        // disable with 5 queued samples: flushed at once, no more pushes
        send_burst(6);
        repeat (2) @(negedge clk);
        bus_rd(BASE + 32'h10, d);
        check("queued_level", d, 32'h5);
        bus_wr(BASE, 32'd0);
        p0 = n_push;
        read = 1; addr = BASE + 32'h10;
        #1 check("disable_flush_status", Rdata, 32'h0002_0000);
        read = 0;
        repeat (20) @(negedge clk);
        check("disable_no_push", 32'(n_push - p0), 32'd0);
        bus_rd(BASE + 32'h0C, d);
        check("disable_keeps_gap", d, 32'd9);

        // synchronous reset in the middle of traffic
        bus_wr(BASE + 32'h04, 32'd5);
        bus_wr(BASE + 32'h08, 32'h2000);
        bus_wr(BASE + 32'h0C, 32'd0);
        bus_wr(BASE, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            raw_valid = 1; raw_sample = 16'($urandom);
        end
        rst = 1;
        @(negedge clk);
        rst = 0; raw_valid = 0;
        reset_table();

        // random traffic with occasional register writes
        bus_wr(BASE + 32'h04, 32'($urandom_range(0, 16'hFFFF)));
        bus_wr(BASE + 32'h08, 32'($urandom_range(16'h0800, 16'h3000)));
        bus_wr(BASE + 32'h0C, 32'($urandom_range(0, 3)));
        bus_wr(BASE, 32'd1);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            raw_valid  = ($urandom_range(0, 9) < 7);
            raw_sample = 16'($urandom);
            r = $urandom_range(0, 59);
            write = 1;
            case (r)
                0: begin addr = BASE + 32'h04; Wdata = $urandom; end
                1: begin addr = BASE + 32'h08; Wdata = $urandom & 32'h3FFF; end
                2: begin addr = BASE + 32'h0C; Wdata = 32'($urandom_range(0, 3)); end
                3: begin addr = BASE + 32'h10; Wdata = $urandom; end
                4: begin addr = BASE;          Wdata = 32'($urandom_range(0, 3)); end
                5: begin addr = BASE;          Wdata = 32'd1; end
                default: write = 0;
            endcase
        end
        @(negedge clk);
        write = 0; raw_valid = 0;
        repeat (100) @(negedge clk);
        bus_rd(BASE + 32'h14, d);
        check("rand_dropcnt", d, m_drop);
        bus_rd(BASE + 32'h18, d);
        check("rand_satcnt", d, m_sat);
        bus_rd(BASE + 32'h10, d);
        check("rand_status", d, model_status());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
